seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
- Parametrised successor to the fixed 3-bit-state sequence detector.
- Detects an arbitrary PAT_LEN-bit serial pattern on X, one bit per step qualifier (debounced one-shot), in the 100 MHz domain.
- Selectable Moore/Mealy output (M) at run time; overlap or non-overlap detection chosen at build time.
- Exports match progress Q for the 7-segment digit and a saturating match counter.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal 2..15.
- PATTERN, 4'b1011, pattern bits; PATTERN[PAT_LEN-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- CNT_W, 8, width of the match counter.

Ports:
- clk100mhz  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- step  input  1  one-cycle step qualifier from the debounce one-shot; each high cycle is one step.
- X  input  1  serial data bit, sampled on step.
- M  input  1  output mode: 0 = Moore, 1 = Mealy.
- Z  output  1  detect output.
- Q  output  4  match progress, 0..PAT_LEN-1.
- match_count  output  CNT_W  number of matches detected, saturating.

Behaviour:
- Internal state:
  - hist[PAT_LEN-1:0]: shift register of the most recent bits, newest in bit 0.
  - fill: 0..PAT_LEN, count of valid bits in hist.
  - z_moore: registered match flag.
  - match_count.
- Reset (reset low, async): hist=0, fill=0, z_moore=0, match_count=0. Outputs then read Z=0, Q=0, match_count=0. Reset dominates a coincident step.
- Step cycle (step=1 at posedge):
  - window = {hist[PAT_LEN-2:0], X}.
  - hit = (fill >= PAT_LEN-1) && (window == PATTERN).
  - hist <= window.
  - fill: if hit && OVERLAP=0, fill <= 0; else fill <= min(fill+1, PAT_LEN).
  - z_moore <= hit.
  - If hit and match_count is not all-ones, match_count increments. It saturates at 2^CNT_W-1.
- Non-step cycle: all state holds.
- Z output:
  - M=0 (Moore): Z = z_moore. Z goes high the cycle after the completing step and stays high until the next step.
  - M=1 (Mealy): Z is combinational, (fill >= PAT_LEN-1) && ({hist[PAT_LEN-2:0], X} == PATTERN). It is independent of step and shows whether the current X would complete a match.
  - A change of M takes effect on Z immediately and does not disturb state.
- Q output (combinational):
  - Q = largest k in 0..PAT_LEN-1 with k <= fill and hist[k-1:0] == PATTERN[PAT_LEN-1 -: k]; k=0 is always true.
  - After a full match with OVERLAP=1, Q equals the longest proper prefix-suffix of PATTERN.
  - With OVERLAP=0, Q=0 after a match.
- Back-to-back step cycles are legal; each cycle is processed as a separate step.
- No latency beyond one clock from step to registered state.

Optional Feature:
- Macro: SEQ_DET_STICKY_EN.
- When defined:
  - Adds input clr_sticky (1 bit) and output sticky (1 bit).
  - sticky sets on the clock of any hit and holds until clr_sticky=1 or reset.
  - If hit and clr_sticky occur in the same cycle, sticky ends set (hit wins).
  - sticky resets to 0.
- When undefined: no extra ports or logic; behaviour is otherwise identical.

Test Plan:
- Reset check: hold reset low with step pulses and X toggling; release. Required: Z=0, Q=0, match_count=0 throughout. The first step after release gives Q=1 if X=1, Q=0 if X=0.
- Progress trace (PATTERN=1011, OVERLAP=1, M=0): steps X=1,0,1,1. Required:
  - Q = 1, 2, 3, 1 after each step.
  - Z high from the cycle after step 4 until step 5.
  - match_count=1.
- Overlap (OVERLAP=1): stream 1,0,1,1,0,1,1. Required: hits on steps 4 and 7; match_count=2. The same stream with OVERLAP=0 gives one hit at step 4, Q=0 after it, and match_count=1.
- Mealy timing (M=1): after steps 1,0,1, drive X=1 without a step. Required: Z=1 immediately. Setting X=0 gives Z=0. Toggling M to 0 gives Z = z_moore = 0 with no state change.
- Saturation (CNT_W=2): six back-to-back 1011 patterns on consecutive step cycles. Required: match_count goes 1, 2, 3 and stays at 3.
- Async reset mid-pattern: after 1,0,1, pulse reset low between clock edges. Required: Q=0, fill=0 immediately. A following 1 gives Q=1, not a match.

Source files
------------

// File: rtl/seq_pattern_detector_if.sv
// Serial pattern detector bus: step/data/mode inputs and detect/progress/count
// outputs. Optional macro SEQ_DET_STICKY_EN adds clr_sticky and sticky.
interface seq_pattern_detector_if #(
    parameter int CNT_W = 8
);
    logic             step;
    logic             X;
    logic             M;
    logic             Z;
    logic [3:0]       Q;
    logic [CNT_W-1:0] match_count;
`ifdef SEQ_DET_STICKY_EN
    logic             clr_sticky;
    logic             sticky;

    modport master (
        output step, X, M, clr_sticky,
        input  Z, Q, match_count, sticky
    );

    modport slave (
        input  step, X, M, clr_sticky,
        output Z, Q, match_count, sticky
    );
`else
    modport master (
        output step, X, M,
        input  Z, Q, match_count
    );

    modport slave (
        input  step, X, M,
        output Z, Q, match_count
    );
`endif
endinterface

// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector with run-time Moore/Mealy output,
// build-time overlap selection, match progress and a saturating match counter.
// Optional macro SEQ_DET_STICKY_EN adds a sticky hit flag with explicit clear.
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input logic                     clk100mhz,
    input logic                     reset,
    seq_pattern_detector_if.slave   bus
);

    localparam int             FW       = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FILL_THR = FW'(PAT_LEN - 1);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN);

    // The oldest history bit falls out of every window the moment it is
    // shifted in, so only PAT_LEN-1 bits of history are ever stored.
    logic [PAT_LEN-2:0] r_hist;
    logic [FW-1:0]      r_fill;
    logic               r_zMoore;
    logic [CNT_W-1:0]   r_count;

    logic [PAT_LEN-2:0] w_histNext;
    logic [FW-1:0]      w_fillNext;
    logic               w_zNext;
    logic [CNT_W-1:0]   w_countNext;

    logic [PAT_LEN-1:0] w_window;
    logic               w_hit;
    logic [PAT_LEN-1:1] w_sufMatch;
    logic [3:0]         w_q;

    assign w_window = {r_hist, bus.X};
    assign w_hit    = (r_fill >= FILL_THR) && (w_window == PATTERN);

    // Suffix k of the history matches the first k pattern bits and is valid.
    for (genvar k = 1; k < PAT_LEN; k++) begin : g_suf
        assign w_sufMatch[k] = (r_fill >= FW'(k)) &&
                               (r_hist[k-1:0] == PATTERN[PAT_LEN-1 -: k]);
    end

    // Next-state: shift in X and update fill/count only on step cycles.
    always_comb begin
        w_histNext  = r_hist;
        w_fillNext  = r_fill;
        w_zNext     = r_zMoore;
        w_countNext = r_count;
        if (bus.step) begin
            w_histNext = w_window[PAT_LEN-2:0];
            w_zNext    = w_hit;
            if (w_hit && !OVERLAP) begin
                w_fillNext = '0;
            end else if (r_fill != FILL_MAX) begin
                w_fillNext = r_fill + 1'b1;
            end
            if (w_hit && !(&r_count)) begin
                w_countNext = r_count + 1'b1;
            end
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            r_hist   <= '0;
            r_fill   <= '0;
            r_zMoore <= 1'b0;
            r_count  <= '0;
        end else begin
            r_hist   <= w_histNext;
            r_fill   <= w_fillNext;
            r_zMoore <= w_zNext;
            r_count  <= w_countNext;
        end
    end

    // Progress is the longest valid history suffix that is a pattern prefix.
    always_comb begin
        w_q = '0;
        for (int k = 1; k < PAT_LEN; k++) begin
            if (w_sufMatch[k]) begin
                w_q = 4'(k);
            end
        end
    end

    // Outputs: M selects the live (Mealy) or registered (Moore) detect.
    always_comb begin
        bus.Z           = bus.M ? w_hit : r_zMoore;
        bus.Q           = w_q;
        bus.match_count = r_count;
    end

`ifdef SEQ_DET_STICKY_EN
    logic r_sticky;

    // Sticky flag: a hit sets it and takes priority over a coincident clear.
    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            r_sticky <= 1'b0;
        end else if (bus.step && w_hit) begin
            r_sticky <= 1'b1;
        end else if (bus.clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign bus.sticky = r_sticky;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: three instances share stimulus
// (overlap/CNT_W=8, non-overlap/CNT_W=8, overlap/CNT_W=2). Pattern is 1011.
module tb_seq_pattern_detector;

    logic clk;
    logic reset;
    logic tStep;
    logic tX;
    logic tM;
    logic tClr;

    int total;
    int bad;

    seq_pattern_detector_if #(.CNT_W(8)) ifA ();
    seq_pattern_detector_if #(.CNT_W(8)) ifB ();
    seq_pattern_detector_if #(.CNT_W(2)) ifC ();

    assign ifA.step = tStep;
    assign ifA.X    = tX;
    assign ifA.M    = tM;
    assign ifB.step = tStep;
    assign ifB.X    = tX;
    assign ifB.M    = tM;
    assign ifC.step = tStep;
    assign ifC.X    = tX;
    assign ifC.M    = tM;
`ifdef SEQ_DET_STICKY_EN
    assign ifA.clr_sticky = tClr;
    assign ifB.clr_sticky = tClr;
    assign ifC.clr_sticky = tClr;
`endif

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dutA (
        .clk100mhz (clk),
        .reset     (reset),
        .bus       (ifA.slave)
    );

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dutB (
        .clk100mhz (clk),
        .reset     (reset),
        .bus       (ifB.slave)
    );

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dutC (
        .clk100mhz (clk),
        .reset     (reset),
        .bus       (ifC.slave)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One step cycle: drive at a falling edge, returns at the next falling edge.
    task automatic applyStimulus(input logic x);
        tStep = 1'b1;
        tX    = x;
        @(negedge clk);
        tStep = 1'b0;
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Linear directed sequence.
    initial begin
        logic [3:0] pat;
        int         expC;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        tStep = 1'b0;
        tX    = 1'b0;
        tM    = 1'b0;
        tClr  = 1'b0;
        pat   = 4'b1011;

        $display("[TB] reset held with steps");
        @(negedge clk);
        applyStimulus(1'b1);
        checkOutput("rst_a_z", ifA.Z, 0);
        checkOutput("rst_a_q", ifA.Q, 0);
        checkOutput("rst_a_cnt", ifA.match_count, 0);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("rst_a_q2", ifA.Q, 0);
        checkOutput("rst_b_q", ifB.Q, 0);
        checkOutput("rst_c_cnt", ifC.match_count, 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rel_a_q", ifA.Q, 0);
        checkOutput("rel_a_z", ifA.Z, 0);

        $display("[TB] progress trace 1011, Moore");
        applyStimulus(1'b1);
        checkOutput("s1_a_q", ifA.Q, 1);
        checkOutput("s1_b_q", ifB.Q, 1);
        applyStimulus(1'b0);
        checkOutput("s2_a_q", ifA.Q, 2);
        applyStimulus(1'b1);
        checkOutput("s3_a_q", ifA.Q, 3);
        checkOutput("s3_a_z", ifA.Z, 0);
        applyStimulus(1'b1);
        checkOutput("s4_a_q", ifA.Q, 1);
        checkOutput("s4_a_z", ifA.Z, 1);
        checkOutput("s4_a_cnt", ifA.match_count, 1);
        checkOutput("s4_b_q", ifB.Q, 0);
        checkOutput("s4_b_z", ifB.Z, 1);
        checkOutput("s4_b_cnt", ifB.match_count, 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_a_z", ifA.Z, 1);
        checkOutput("hold_a_q", ifA.Q, 1);
`ifdef SEQ_DET_STICKY_EN
        checkOutput("sticky_set", ifA.sticky, 1);
        tClr = 1'b1;
        @(negedge clk);
        tClr = 1'b0;
        checkOutput("sticky_clr", ifA.sticky, 0);
`endif

        $display("[TB] overlap stream continues 0,1,1");
        applyStimulus(1'b0);
        checkOutput("s5_a_z", ifA.Z, 0);
        checkOutput("s5_a_q", ifA.Q, 2);
        checkOutput("s5_b_q", ifB.Q, 0);
        applyStimulus(1'b1);
        checkOutput("s6_a_q", ifA.Q, 3);
        checkOutput("s6_b_q", ifB.Q, 1);
        applyStimulus(1'b1);
        checkOutput("s7_a_z", ifA.Z, 1);
        checkOutput("s7_a_q", ifA.Q, 1);
        checkOutput("s7_a_cnt", ifA.match_count, 2);
        checkOutput("s7_c_cnt", ifC.match_count, 2);
        checkOutput("s7_b_z", ifB.Z, 0);
        checkOutput("s7_b_q", ifB.Q, 1);
        checkOutput("s7_b_cnt", ifB.match_count, 1);

        $display("[TB] async reset then Mealy timing");
        #2 reset = 1'b0;
        #1;
        checkOutput("ar1_a_q", ifA.Q, 0);
        checkOutput("ar1_a_cnt", ifA.match_count, 0);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("pre_mealy_q", ifA.Q, 3);
        tM = 1'b1;
        tX = 1'b1;
        #1;
        checkOutput("mealy_a_z1", ifA.Z, 1);
        checkOutput("mealy_b_z1", ifB.Z, 1);
        tX = 1'b0;
        #1;
        checkOutput("mealy_a_z0", ifA.Z, 0);
        tX = 1'b1;
        tM = 1'b0;
        #1;
        checkOutput("moore_back_z", ifA.Z, 0);
        checkOutput("moore_back_q", ifA.Q, 3);
        checkOutput("moore_back_cnt", ifA.match_count, 0);
        @(negedge clk);
        checkOutput("nostep_q", ifA.Q, 3);

        $display("[TB] async reset mid-pattern");
        #2 reset = 1'b0;
        #1;
        checkOutput("ar2_a_q", ifA.Q, 0);
        checkOutput("ar2_a_z", ifA.Z, 0);
        checkOutput("ar2_c_q", ifC.Q, 0);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1);
        checkOutput("ar2_next_q", ifA.Q, 1);
        checkOutput("ar2_next_z", ifA.Z, 0);
        checkOutput("ar2_next_cnt", ifA.match_count, 0);

        $display("[TB] saturation with back-to-back patterns");
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        tStep = 1'b1;
        for (int p = 0; p < 6; p++) begin
            for (int b = 3; b >= 0; b--) begin
                tX = pat[b];
                @(negedge clk);
            end
            expC = (p + 1 > 3) ? 3 : p + 1;
            checkOutput("sat_c_cnt", ifC.match_count, expC);
        end
        tStep = 1'b0;
        checkOutput("sat_a_cnt", ifA.match_count, 6);
        checkOutput("sat_b_cnt", ifB.match_count, 6);
        checkOutput("sat_c_z", ifC.Z, 1);
        @(negedge clk);
        checkOutput("sat_c_hold", ifC.match_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
